// File: rtl/npu_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_mac_pkg
// Purpose  : Shared default widths and saturate / rounding-shift helpers.
// Revision : 1.0
// ============================================================================
package npu_mac_pkg;

   localparam int DEF_LANES       = 4;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_BIAS_W      = 8;
   localparam int DEF_BIAS_SIGNED = 0;
   localparam int DEF_ACC_W       = 24;
   localparam int DEF_OUT_W       = 16;
   localparam int DEF_SHIFT_W     = 5;

   // Wide signed working type; every lane width fits with headroom.
   localparam int CALC_W = 64;
   typedef logic signed [CALC_W-1:0] calc_t;

   function automatic calc_t sat_signed(input calc_t value, input int width);
      calc_t max_v;
      calc_t min_v;
      max_v = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
      min_v = -(calc_t'(1) <<< (width - 1));
      if (value > max_v)
         sat_signed = max_v;
      else if (value < min_v)
         sat_signed = min_v;
      else
         sat_signed = value;
   endfunction

   // Round half up, then arithmetic shift right.
   function automatic calc_t round_shift(input calc_t value, input int shift);
      calc_t t;
      if (shift > 0)
         t = value + (calc_t'(1) <<< (shift - 1));
      else
         t = value;
      round_shift = t >>> shift;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : mac_lane
// Purpose  : One MAC lane: product register, saturating accumulator,
//            requantiser and sticky overflow flag.
// Revision : 1.0
// ============================================================================
module mac_lane
   import npu_mac_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int BIAS_W      = DEF_BIAS_W,
   parameter int BIAS_SIGNED = DEF_BIAS_SIGNED,
   parameter int ACC_W       = DEF_ACC_W,
   parameter int OUT_W       = DEF_OUT_W,
   parameter int SHIFT_W     = DEF_SHIFT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic               i_v1,
   input  logic               i_clr1,
   input  logic               i_last1,
   input  logic [SHIFT_W-1:0] i_shift1,
   input  logic [DATA_W-1:0]  i_a,
   input  logic [DATA_W-1:0]  i_b,
   input  logic [BIAS_W-1:0]  i_bias,
   output logic [OUT_W-1:0]   o_y,
   output logic               o_ovf
);

   logic signed [2*DATA_W-1:0] prod_d, prod_q;
   logic signed [ACC_W-1:0]    bias_ext, bias_d, bias_q;
   logic signed [ACC_W-1:0]    acc_d, acc_q;
   logic [OUT_W-1:0]           y_d, y_q;
   logic                       ovf_d, ovf_q;

   calc_t sum, sum_sat, rnd, rnd_sat;
   int    sh;
   logic  acc_ovf, out_ovf;

   generate
      if (BIAS_SIGNED != 0) begin : g_bias_sext
         assign bias_ext = ACC_W'($signed(i_bias));
      end else begin : g_bias_zext
         assign bias_ext = ACC_W'(i_bias);
      end
   endgenerate

   always_comb begin
      prod_d = prod_q;
      bias_d = bias_q;
      if (i_en) begin
         prod_d = (2*DATA_W)'($signed(i_a)) * (2*DATA_W)'($signed(i_b));
         bias_d = bias_ext;
      end

      sum     = (i_clr1 ? calc_t'(bias_q) : calc_t'(acc_q)) + calc_t'(prod_q);
      sum_sat = sat_signed(sum, ACC_W);
      acc_ovf = (sum_sat != sum);
      sh      = (int'(i_shift1) >= ACC_W) ? ACC_W - 1 : int'(i_shift1);
      rnd     = round_shift(sum_sat, sh);
      rnd_sat = sat_signed(rnd, OUT_W);
      out_ovf = (rnd_sat != rnd);

      acc_d = acc_q;
      ovf_d = ovf_q;
      y_d   = y_q;
      if (i_en && i_v1) begin
         acc_d = ACC_W'(sum_sat);
         ovf_d = (i_clr1 ? 1'b0 : ovf_q) | acc_ovf;
         if (i_last1) begin
            y_d   = OUT_W'(rnd_sat);
            ovf_d = ovf_d | out_ovf;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q <= '0;
         bias_q <= '0;
         acc_q  <= '0;
         y_q    <= '0;
         ovf_q  <= 1'b0;
      end else begin
         prod_q <= prod_d;
         bias_q <= bias_d;
         acc_q  <= acc_d;
         y_q    <= y_d;
         ovf_q  <= ovf_d;
      end
   end

   assign o_y   = y_q;
   assign o_ovf = ovf_q;

endmodule
`default_nettype wire

// File: rtl/mac_array_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_pipe
// Purpose  : LANES-wide pipelined MAC array sharing one valid/clr/last stream.
// Revision : 1.0
// ============================================================================
module mac_array_pipe
   import npu_mac_pkg::*;
#(
   parameter int LANES       = DEF_LANES,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int BIAS_W      = DEF_BIAS_W,
   parameter int BIAS_SIGNED = DEF_BIAS_SIGNED,
   parameter int ACC_W       = DEF_ACC_W,
   parameter int OUT_W       = DEF_OUT_W,
   parameter int SHIFT_W     = DEF_SHIFT_W
) (
   input  logic                     CLKEXT,
   input  logic                     RSTEXT,
   input  logic                     EN_MAC,
   input  logic                     VALID_IN,
   input  logic                     CLR_MAC,
   input  logic                     LAST_MAC,
   input  logic [LANES*DATA_W-1:0]  A,
   input  logic [LANES*DATA_W-1:0]  B,
   input  logic [LANES*BIAS_W-1:0]  BIAS_IN,
   input  logic [SHIFT_W-1:0]       OUT_SHIFT,
   output logic [LANES*OUT_W-1:0]   Y,
   output logic                     VALID_OUT,
   output logic [LANES-1:0]         OVF
);

   logic               v1_d, v1_q;
   logic               clr1_d, clr1_q;
   logic               last1_d, last1_q;
   logic [SHIFT_W-1:0] shift1_d, shift1_q;
   logic               vout_d, vout_q;

   always_comb begin
      v1_d     = v1_q;
      clr1_d   = clr1_q;
      last1_d  = last1_q;
      shift1_d = shift1_q;
      vout_d   = 1'b0;
      if (EN_MAC) begin
         v1_d     = VALID_IN;
         clr1_d   = CLR_MAC;
         last1_d  = LAST_MAC;
         shift1_d = OUT_SHIFT;
         vout_d   = v1_q && last1_q;
      end
   end

   always_ff @(posedge CLKEXT or posedge RSTEXT) begin
      if (RSTEXT) begin
         v1_q     <= 1'b0;
         clr1_q   <= 1'b0;
         last1_q  <= 1'b0;
         shift1_q <= '0;
         vout_q   <= 1'b0;
      end else begin
         v1_q     <= v1_d;
         clr1_q   <= clr1_d;
         last1_q  <= last1_d;
         shift1_q <= shift1_d;
         vout_q   <= vout_d;
      end
   end

   assign VALID_OUT = vout_q;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         mac_lane #(
            .DATA_W      (DATA_W),
            .BIAS_W      (BIAS_W),
            .BIAS_SIGNED (BIAS_SIGNED),
            .ACC_W       (ACC_W),
            .OUT_W       (OUT_W),
            .SHIFT_W     (SHIFT_W)
         ) u_lane (
            .clk      (CLKEXT),
            .rst      (RSTEXT),
            .i_en     (EN_MAC),
            .i_v1     (v1_q),
            .i_clr1   (clr1_q),
            .i_last1  (last1_q),
            .i_shift1 (shift1_q),
            .i_a      (A[i*DATA_W +: DATA_W]),
            .i_b      (B[i*DATA_W +: DATA_W]),
            .i_bias   (BIAS_IN[i*BIAS_W +: BIAS_W]),
            .o_y      (Y[i*OUT_W +: OUT_W]),
            .o_ovf    (OVF[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/mac_array_pipe.md
Name: mac_array_pipe

Overview:
- Parametrised, pipelined multi-lane successor of the NPU single-lane MAC.
- LANES independent signed multiply-accumulate lanes share one control stream (VALID/CLR/LAST).
- Each lane seeds from a per-lane bias, saturates at ACC_W, then requantises to OUT_W by rounding right shift with saturation.
- Sits between the operand fetch unit and the activation stage; one result vector per accumulation burst.

Parameters:
- LANES, 4, number of parallel MAC lanes
- DATA_W, 8, signed operand width of A and B
- BIAS_W, 8, per-lane bias width
- BIAS_SIGNED, 0, 0 = zero-extend bias, 1 = sign-extend bias
- ACC_W, 24, signed accumulator width; must be ≥ 2*DATA_W+1
- OUT_W, 16, signed output width; must be ≤ ACC_W
- SHIFT_W, 5, width of OUT_SHIFT

Ports:
- CLKEXT  in  1  clock; all state updates on the rising edge
- RSTEXT  in  1  asynchronous, active-high reset
- EN_MAC  in  1  global enable; low = stall, all pipeline state holds
- VALID_IN  in  1  input beat valid
- CLR_MAC  in  1  beat starts a new burst: acc = bias + product
- LAST_MAC  in  1  beat ends the burst and produces an output
- A  in  LANES*DATA_W  signed operands, lane i at [i*DATA_W +: DATA_W]
- B  in  LANES*DATA_W  signed operands, same packing as A
- BIAS_IN  in  LANES*BIAS_W  per-lane bias, sampled on CLR_MAC beats
- OUT_SHIFT  in  SHIFT_W  requantisation right shift, sampled per beat
- Y  out  LANES*OUT_W  signed requantised results
- VALID_OUT  out  1  one-cycle pulse: Y holds a new result
- OVF  out  LANES  sticky per-lane saturation flag for the current burst

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - Y=0, VALID_OUT=0, OVF=0.
  - Accumulators and all stage-1 registers are 0, with their valid bit cleared.
  - Any in-flight burst is discarded; the first beat after reset needs CLR_MAC to be meaningful.
- Stage 1, edge k, when EN_MAC=1:
  - Register the per-lane product p = A*B (2*DATA_W signed), VALID_IN, CLR_MAC, LAST_MAC, OUT_SHIFT and the extended bias.
  - Bias extension is zero or sign according to BIAS_SIGNED, to ACC_W.
- Stage 2, edge k+1, when EN_MAC=1 and stage-1 valid:
  - s = (clr ? bias : acc) + sext(p), computed in ACC_W+1 bits.
  - On signed overflow, clamp to max or min of ACC_W and set that lane's OVF.
  - CLR clears OVF before applying the new overflow result.
- Output, same edge k+1, if the stage-1 beat had LAST:
  - r = s_sat (the value being written to acc).
  - If shift>0, add 2^(shift-1) in ACC_W+1 bits, then arithmetic shift right (round half up).
  - Shift ≥ ACC_W is clamped to ACC_W-1.
  - Saturate to OUT_W; if clamped, set OVF.
  - Write Y and set VALID_OUT=1.
- VALID_OUT is 0 after every edge that does not produce a result, including stalled edges. Y holds its last value.
- Latency: LAST beat sampled at edge k gives VALID_OUT high in the cycle after edge k+1. Full throughput: one beat per cycle, back-to-back bursts with no bubble.
- Bubbles: VALID_IN=0 beats leave acc, OVF and Y unchanged. CLR_MAC/LAST_MAC are ignored when VALID_IN=0.
- Single-beat burst: CLR_MAC=LAST_MAC=1 gives Y = requant(bias+A*B).
- LAST without a prior CLR: accumulation continues from the current acc; this is legal.
- EN_MAC=0: both stages freeze; a pending stage-1 beat completes on the next enabled edge.
- OVF remains readable after VALID_OUT until the next CLR beat reaches stage 2.

Decomposition:
- Shared package npu_mac_pkg holds:
  - default widths
  - function sat_signed(value, width)
  - function round_shift(value, shift)
- One natural sub-module: mac_lane holds one lane's stage-1 product, accumulator, saturation, requantiser and OVF.
- mac_array_pipe generates LANES instances and owns the shared control pipeline (valid, clr, last, shift).

Test Plan:
- Single beat, lane0: CLR=LAST=1, A=3, B=4, BIAS=5, shift=0 → VALID_OUT pulse 2 edges later; Y0=17, OVF0=0.
- 4-beat burst: A=-128, B=-128 every beat, bias=0, shift=0 → acc 65536; output saturates to Y0=32767, OVF0=1. The next CLR burst (A=1, B=1, bias=0) gives Y0=1, OVF0=0.
- Rounding: bias=0, product 0x0180, shift=8 → Y=2 (1.5 rounds up). Product -384, shift=8 → Y=-1 (-1.5 rounds to -1).
- BIAS_SIGNED=1, bias=0xFF, A=B=0 → Y=-1. With BIAS_SIGNED=0, same stimulus → Y=255.
- Stall and bubbles: burst of 3 beats (2×3 each) with VALID_IN=0 and EN_MAC=0 gaps inserted → Y=18, exactly one VALID_OUT pulse. Back-to-back bursts give consecutive pulses.
- Reset mid-burst: assert RSTEXT after 2 beats → Y=0, VALID_OUT=0, OVF=0 immediately. A new CLR burst A=2, B=2, bias=0 gives Y=4.
